// File: rtl/alu_mdu_pkg.sv
// Shared types for the execute-stage ALU with iterative multiply/divide:
// operation codes, FSM states and op-class helpers.
package alu_mdu_pkg;

  typedef enum logic [4:0] {
    OP_ADD     = 5'h00,
    OP_SUB     = 5'h01,
    OP_AND     = 5'h02,
    OP_OR      = 5'h03,
    OP_XOR     = 5'h04,
    OP_PASSA   = 5'h05,
    OP_ADD4    = 5'h06,
    OP_SLTU    = 5'h07,
    OP_SLT     = 5'h08,
    OP_SLL     = 5'h09,
    OP_SRL     = 5'h0A,
    OP_SRA     = 5'h0B,
    OP_PASSB   = 5'h0C,
    OP_PASSA2  = 5'h0D,
    OP_PASSB2  = 5'h0E,
    OP_ABSDIFF = 5'h0F,
    OP_MUL     = 5'h10,
    OP_MULH    = 5'h11,
    OP_MULHSU  = 5'h12,
    OP_MULHU   = 5'h13,
    OP_DIV     = 5'h14,
    OP_DIVU    = 5'h15,
    OP_REM     = 5'h16,
    OP_REMU    = 5'h17
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_ITER  = 3'd2,
    ST_FIX   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Codes 0x10-0x17 run through the iterative multiply/divide datapath.
  function automatic logic is_multicycle(input logic [4:0] op);
    return (op[4:3] == 2'b10);
  endfunction

  // Codes 0x18-0x1F are undefined and complete in one cycle with result 0.
  function automatic logic is_illegal(input logic [4:0] op);
    return (op[4:3] == 2'b11);
  endfunction

endpackage

// File: rtl/alu_mdu_basic.sv
// Single-cycle combinational ALU covering op codes 0x00-0x0F.
// Shifts use only the low SHW bits of b, so the amount is always < XLEN.
module alu_basic
  import alu_mdu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] res_o
);

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  logic [SHW-1:0] shamt_s;
  logic           lt_s;
  logic           ltu_s;

  assign shamt_s = b_i[SHW-1:0];
  assign lt_s    = ($signed(a_i) < $signed(b_i));
  assign ltu_s   = (a_i < b_i);

  // Basic operation select; undefined codes produce zero
  always_comb begin
    res_o = '0;
    case (op_i)
      OP_ADD:     res_o = a_i + b_i;
      OP_SUB:     res_o = a_i - b_i;
      OP_AND:     res_o = a_i & b_i;
      OP_OR:      res_o = a_i | b_i;
      OP_XOR:     res_o = a_i ^ b_i;
      OP_PASSA:   res_o = a_i;
      OP_ADD4:    res_o = a_i + FOUR;
      OP_SLTU:    res_o = {{(XLEN-1){1'b0}}, ltu_s};
      OP_SLT:     res_o = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLL:     res_o = a_i << shamt_s;
      OP_SRL:     res_o = a_i >> shamt_s;
      OP_SRA:     res_o = $signed(a_i) >>> shamt_s;
      OP_PASSB:   res_o = b_i;
      OP_PASSA2:  res_o = a_i;
      OP_PASSB2:  res_o = b_i;
      OP_ABSDIFF: res_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
      default:    res_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with valid/ready handshakes on both sides. Basic ops
// finish in one cycle; MUL/DIV/REM families run a radix-2 shift-add or a
// restoring divide over XLEN iterations on one shared XLEN+1-bit adder,
// with operands reduced to magnitudes up front and signs fixed at the end.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN),
  parameter int CNTW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] alu_a,
  input  logic [XLEN-1:0] alu_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_out,
  output logic            busy
);

  state_e              state_q, state_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;     // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]     dvs_q, dvs_d;     // multiplicand or divisor magnitude
  logic [4:0]          op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic                neg_q, neg_d;     // product / quotient must be negated
  logic                rneg_q, rneg_d;   // remainder must be negated (dividend sign)
  logic [XLEN-1:0]     res_q, res_d;

  logic                accept_s;
  logic [XLEN-1:0]     basic_res_s;
  logic                a_sgn_s, b_sgn_s;
  logic [XLEN-1:0]     mag_a_s, mag_b_s;
  logic [XLEN:0]       add_a_s, add_b_s, sum_s;
  logic                add_sub_s;
  logic [2*XLEN-1:0]   prod_s;
  logic [XLEN-1:0]     quo_s, rem_s;

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept_s  = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_SETUP) || (state_q == ST_ITER) || (state_q == ST_FIX);
  assign alu_out   = res_q;

  alu_basic #(
    .XLEN (XLEN),
    .SHW  (SHW)
  ) u_basic (
    .op_i  (op),
    .a_i   (alu_a),
    .b_i   (alu_b),
    .res_o (basic_res_s)
  );

  // Operand signedness: a is signed for MULH/MULHSU/DIV/REM, b for MULH/DIV/REM
  assign a_sgn_s = a_q[XLEN-1] && ((op_q == OP_MULH) || (op_q == OP_MULHSU) ||
                                   (op_q == OP_DIV)  || (op_q == OP_REM));
  assign b_sgn_s = b_q[XLEN-1] && ((op_q == OP_MULH) || (op_q == OP_DIV) ||
                                   (op_q == OP_REM));
  assign mag_a_s = a_sgn_s ? -a_q : a_q;
  assign mag_b_s = b_sgn_s ? -b_q : b_q;

  // Shared adder/subtractor: a + b, or a + ~b + 1 when subtracting
  assign sum_s = add_a_s + (add_b_s ^ {(XLEN+1){add_sub_s}}) + {{XLEN{1'b0}}, add_sub_s};

  // Sign fixup views of the finished accumulator
  assign prod_s = neg_q  ? -acc_q : acc_q;
  assign quo_s  = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_s  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  // Adder operand mux: divide trial-subtracts the shifted remainder, multiply adds the multiplicand
  always_comb begin
    add_b_s = {1'b0, dvs_q};
    if (op_q[2]) begin
      add_a_s   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      add_sub_s = 1'b1;
    end else begin
      add_a_s   = {1'b0, acc_q[2*XLEN-1:XLEN]};
      add_sub_s = 1'b0;
    end
  end

  // FSM next state, iteration datapath and result selection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_SETUP: begin
        acc_d  = {{XLEN{1'b0}}, mag_a_s};
        dvs_d  = mag_b_s;
        rneg_d = a_sgn_s;
        // A zero divisor yields an all-ones quotient whatever the signs
        if (op_q[2]) begin
          neg_d = (a_sgn_s ^ b_sgn_s) && (|b_q);
        end else begin
          neg_d = a_sgn_s ^ b_sgn_s;
        end
        cnt_d   = CNTW'(XLEN);
        state_d = ST_ITER;
      end
      ST_ITER: begin
        if (op_q[2]) begin
          // Borrow out of the XLEN+1-bit subtract means the trial failed: restore
          if (!sum_s[XLEN]) begin
            acc_d = {sum_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d = {add_a_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
          end
        end else begin
          if (acc_q[0]) begin
            acc_d = {sum_s, acc_q[XLEN-1:1]};
          end else begin
            acc_d = {1'b0, acc_q[2*XLEN-1:1]};
          end
        end
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_ITER;
        end
      end
      ST_FIX: begin
        case (op_q)
          OP_MUL:                       res_d = prod_s[XLEN-1:0];
          OP_MULH, OP_MULHSU, OP_MULHU: res_d = prod_s[2*XLEN-1:XLEN];
          OP_DIV, OP_DIVU:              res_d = quo_s;
          OP_REM, OP_REMU:              res_d = rem_s;
          default:                      res_d = '0;
        endcase
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new request may be accepted from IDLE or while the result is being consumed
    if (accept_s) begin
      op_d = op;
      a_d  = alu_a;
      b_d  = alu_b;
      if (is_multicycle(op)) begin
        state_d = ST_SETUP;
      end else begin
        state_d = ST_DONE;
        res_d   = is_illegal(op) ? '0 : basic_res_s;
      end
    end else begin
      op_d = op_d;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      op_q    <= 5'd0;
      a_q     <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: a table of directed vectors, random
// vectors against a 64-bit reference model, back-to-back issue, and a
// mid-operation reset. Expected results go through a scoreboard queue.
module tb_alu_mdu;

  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        op;
  logic [XLEN-1:0]   alu_a;
  logic [XLEN-1:0]   alu_b;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   alu_out;
  logic              busy;

  int n_chk  = 0;
  int n_pass = 0;

  logic [XLEN-1:0] sb[$];

  typedef struct {
    logic [4:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
    int              hold;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl[NV];

  alu_mdu #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name, output logic [XLEN-1:0] e);
    if (sb.size() == 0) begin
      e = '0;
      check({name, " scoreboard empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check(name, alu_out, e);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_model(input logic [4:0] o, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    logic [63:0] p;
    longint      sa, sb_, ub;
    logic [4:0]  sh;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    ub  = longint'({32'h0, b});
    sh  = b[4:0];
    case (o)
      5'h00: return a + b;
      5'h01: return a - b;
      5'h02: return a & b;
      5'h03: return a | b;
      5'h04: return a ^ b;
      5'h05, 5'h0D: return a;
      5'h06: return a + 32'd4;
      5'h07: return (a < b) ? 32'd1 : 32'd0;
      5'h08: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'h09: return a << sh;
      5'h0A: return a >> sh;
      5'h0B: return $signed(a) >>> sh;
      5'h0C, 5'h0E: return b;
      5'h0F: return (a >= b) ? (a - b) : (b - a);
      5'h10: begin p = sa * sb_;                 return p[31:0];  end
      5'h11: begin p = sa * sb_;                 return p[63:32]; end
      5'h12: begin p = sa * ub;                  return p[63:32]; end
      5'h13: begin p = {32'h0, a} * {32'h0, b};  return p[63:32]; end
      5'h14: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = sa / sb_;
        return p[31:0];
      end
      5'h15: return (b == 32'd0) ? 32'hFFFF_FFFF : (a / b);
      5'h16: begin
        if (b == 32'd0) return a;
        p = sa % sb_;
        return p[31:0];
      end
      5'h17: return (b == 32'd0) ? a : (a % b);
      default: return 32'd0;
    endcase
  endfunction

  // Issue one request from IDLE, wait for its result and check value, latency and busy.
  task automatic run_op(input string name, input logic [4:0] o, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int hold);
    int              k;
    int              busy_n;
    int              exp_rise;
    logic [XLEN-1:0] e;
    exp_rise = (o[4:3] == 2'b10) ? (XLEN + 2) : 0;
    @(negedge clk);
    check({name, " in_ready"}, in_ready, 1'b1);
    in_valid  = 1'b1;
    op        = o;
    alu_a     = a;
    alu_b     = b;
    out_ready = (hold == 0);
    sb.push_back(exp);
    @(negedge clk);
    // Scramble inputs after acceptance: the DUT must use the captured values
    in_valid = 1'b0;
    op       = 5'($urandom);
    alu_a    = $urandom;
    alu_b    = $urandom;
    k = 1;
    busy_n = 0;
    while (!out_valid && (k < 200)) begin
      if (busy) busy_n++;
      @(negedge clk);
      k++;
    end
    check({name, " out_valid"}, out_valid, 1'b1);
    check({name, " rise edge"}, 64'(k - 1), 64'(exp_rise));
    check({name, " busy cycles"}, 64'(busy_n), 64'(exp_rise));
    check({name, " busy low at result"}, busy, 1'b0);
    pop_check({name, " result"}, e);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({name, " held valid"}, out_valid, 1'b1);
      check({name, " held result"}, alu_out, e);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    logic [4:0]      bo[3];
    logic [XLEN-1:0] ba[3], bb[3], e;
    int              acc_cyc[3], out_cyc[3];
    int              idx, got, cyc;
    logic            seen;
    logic [4:0]      ro;
    logic [XLEN-1:0] ra, rb;

    tbl[0]  = '{5'h00, 32'd7,          32'd5,          32'd12,         3};
    tbl[1]  = '{5'h0F, 32'd3,          32'd10,         32'd7,          0};
    tbl[2]  = '{5'h0B, 32'h8000_0000,  32'h0000_0024,  32'hF800_0000,  0};
    tbl[3]  = '{5'h08, 32'hFFFF_FFFF,  32'd1,          32'd1,          0};
    tbl[4]  = '{5'h07, 32'hFFFF_FFFF,  32'd1,          32'd0,          0};
    tbl[5]  = '{5'h11, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  0};
    tbl[6]  = '{5'h10, 32'hFFFF_FFFD,  32'd7,          32'hFFFF_FFEB,  0};
    tbl[7]  = '{5'h14, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  0};
    tbl[8]  = '{5'h16, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  0};
    tbl[9]  = '{5'h15, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  0};
    tbl[10] = '{5'h17, 32'd9,          32'd0,          32'd9,          0};
    tbl[11] = '{5'h14, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0};
    tbl[12] = '{5'h16, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0};
    tbl[13] = '{5'h14, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  0};
    tbl[14] = '{5'h16, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  2};
    tbl[15] = '{5'h12, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  0};
    tbl[16] = '{5'h13, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  0};
    tbl[17] = '{5'h18, 32'd5,          32'd6,          32'd0,          0};
    tbl[18] = '{5'h06, 32'h0000_0010,  32'd99,         32'h0000_0014,  0};
    tbl[19] = '{5'h09, 32'd1,          32'h0000_0021,  32'd2,          0};
    tbl[20] = '{5'h0A, 32'h8000_0000,  32'h0000_001F,  32'd1,          0};
    tbl[21] = '{5'h01, 32'd5,          32'd7,          32'hFFFF_FFFE,  0};
    tbl[22] = '{5'h0C, 32'd1,          32'h0000_ABCD,  32'h0000_ABCD,  0};
    tbl[23] = '{5'h0D, 32'h0000_DEAD,  32'd1,          32'h0000_DEAD,  0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 5'd0; alu_a = '0; alu_b = '0;
    repeat (3) @(negedge clk);
    check("reset out_valid", out_valid, 1'b0);
    check("reset alu_out", alu_out, 32'd0);
    check("reset in_ready", in_ready, 1'b1);
    check("reset busy", busy, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_op($sformatf("vec%0d op%02h", i, tbl[i].op), tbl[i].op, tbl[i].a, tbl[i].b,
             tbl[i].exp, tbl[i].hold);
    end

    for (int i = 0; i < 16; i++) begin
      ro = 5'($urandom_range(0, 31));
      ra = $urandom;
      rb = (i % 4 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      run_op($sformatf("rand%0d op%02h", i, ro), ro, ra, rb, ref_model(ro, ra, rb), 0);
    end

    // Back-to-back: ADD, MUL, ADD with in_valid and out_ready held high
    bo = '{5'h00, 5'h10, 5'h00};
    ba = '{32'd1, 32'd3, 32'd5};
    bb = '{32'd2, 32'd4, 32'd6};
    idx = 0; got = 0; cyc = 0;
    out_ready = 1'b1;
    while ((got < 3) && (cyc < 300)) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        pop_check($sformatf("b2b result %0d", got), e);
        out_cyc[got] = cyc;
        got++;
      end
      if (idx < 3) begin
        in_valid = 1'b1;
        op = bo[idx]; alu_a = ba[idx]; alu_b = bb[idx];
        if (in_ready) begin
          sb.push_back(ref_model(bo[idx], ba[idx], bb[idx]));
          acc_cyc[idx] = cyc;
          idx++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("b2b all results", 64'(got), 64'd3);
    if (got == 3) begin
      check("b2b add0 latency", 64'(out_cyc[0] - acc_cyc[0]), 64'd1);
      check("b2b mul issued on add0 consume", 64'(acc_cyc[1]), 64'(out_cyc[0]));
      check("b2b mul latency", 64'(out_cyc[1] - acc_cyc[1]), 64'(XLEN + 3));
      check("b2b add1 issued on mul consume", 64'(acc_cyc[2]), 64'(out_cyc[1]));
      check("b2b no bubble", 64'(out_cyc[2] - out_cyc[1]), 64'd1);
    end
    @(negedge clk);
    check("b2b drained", out_valid, 1'b0);

    // Reset in the middle of a DIVU: no result may appear afterwards
    in_valid = 1'b1; op = 5'h15; alu_a = 32'h1234_5678; alu_b = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (11) @(negedge clk);
    check("abort busy before reset", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort out_valid", out_valid, 1'b0);
    check("abort in_ready", in_ready, 1'b1);
    check("abort busy", busy, 1'b0);
    check("abort alu_out", alu_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < XLEN + 8; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort no result", seen, 1'b0);
    run_op("post-abort add", 5'h00, 32'd1, 32'd1, 32'd2, 0);

    @(negedge clk);
    check("scoreboard empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
